// File: rtl/muldiv_controller.sv
// Multi-cycle MULTU/DIVU sequencer owning the HI/LO register pair; stalls the front end while busy.
// Optional: define MULDIV_EARLY_TERM_EN to end MUL once the remaining multiplier bits are all zero.
module muldiv_controller #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_rd,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               busy_reg, done_reg;
    logic [CNT_W-1:0]   cnt_reg;

    // Multiply datapath: multiplicand shifts left into a double-width accumulator.
    logic [2*WIDTH-1:0] acc_reg, mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;

    // Restoring divide datapath: quotient register starts holding the dividend.
    logic [WIDTH-1:0]   divisor_reg, quot_reg, rem_reg;

    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   rem_next, quot_next;
    logic               last_iter, mul_finish;

    always_comb begin
        acc_next  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
        shifted   = {rem_reg, quot_reg[WIDTH-1]};
        diff      = shifted - {1'b0, divisor_reg};
        rem_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quot_next = {quot_reg[WIDTH-2:0], ~diff[WIDTH]};
        last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_TERM_EN
        mul_finish = last_iter | (mplier_reg[WIDTH-1:1] == '0);
`else
        mul_finish = last_iter;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            hi_reg      <= '0;
            lo_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            divisor_reg <= '0;
            quot_reg    <= '0;
            rem_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        // A simultaneous mthi/mtlo is dropped; the requester reissues it.
                        state_reg   <= op ? DIV : MUL;
                        busy_reg    <= 1'b1;
                        cnt_reg     <= '0;
                        acc_reg     <= '0;
                        mcand_reg   <= {{WIDTH{1'b0}}, a};
                        mplier_reg  <= b;
                        divisor_reg <= b;
                        quot_reg    <= a;
                        rem_reg     <= '0;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        if (hi_we) hi_reg <= wdata;
                        if (lo_we) lo_reg <= wdata;
                    end
                end
                MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (mul_finish) begin
                        {hi_reg, lo_reg} <= acc_next;
                        state_reg        <= DONE;
                        busy_reg         <= 1'b0;
                        done_reg         <= 1'b1;
                    end
                end
                DIV: begin
                    if (divisor_reg == '0) begin
                        hi_reg    <= quot_reg;
                        lo_reg    <= '1;
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        rem_reg  <= rem_next;
                        quot_reg <= quot_next;
                        cnt_reg  <= cnt_reg + 1'b1;
                        if (last_iter) begin
                            hi_reg    <= rem_next;
                            lo_reg    <= quot_next;
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign hi    = hi_reg;
    assign lo    = lo_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign stall = busy_reg ? (start | hilo_rd | hi_we | lo_we)
                            : (start & (hi_we | lo_we));

endmodule

// File: tb/tb_muldiv_controller.sv
// Scoreboard bench for muldiv_controller: randomized MULTU/DIVU against an arithmetic reference model.
module tb_muldiv_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, op, hilo_rd, hi_we, lo_we;
    logic [31:0] a, b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    muldiv_controller #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hilo_rd(hilo_rd), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc_done;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Done cycle counted from the accepting edge (cycle 1 follows that edge).
    function automatic int latency(input logic o, input logic [31:0] bv);
        int iters;
        if (o) begin
            iters = (bv == 0) ? 1 : 32;
        end else begin
`ifdef MULDIV_EARLY_TERM_EN
            iters = 1;
            for (int i = 0; i < 32; i++) if (bv[i]) iters = i + 1;
`else
            iters = 32;
`endif
        end
        return iters + 1;
    endfunction

    function automatic exp_t model(input logic o, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        longint unsigned p;
        if (!o) begin
            p = longint'(av) * longint'(bv);
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.name = "multu";
        end else if (bv == 0) begin
            e.hi = av;
            e.lo = 32'hFFFF_FFFF;
            e.name = "divu0";
        end else begin
            e.hi = av % bv;
            e.lo = av / bv;
            e.name = "divu";
        end
        e.cyc_done = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc_done));
                check({e.name, "_busy_low"}, 64'(busy), 64'd0);
                $display("op %s hi=0x%08h lo=0x%08h cyc=%0d", e.name, hi, lo, cyc);
            end
        end
    end

    // Issue an op at a negedge, holding start until it is accepted; returns in cycle 1.
    task automatic do_op(input logic o, input logic [31:0] av, input logic [31:0] bv, input bit track);
        exp_t e;
        int guard;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("accept_timeout", 64'd1, 64'd0);
        e = model(o, av, bv);
        e.cyc_done = cyc + latency(o, bv);
        if (track) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; op = $urandom_range(0, 1);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || busy || done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int guard;
        logic [31:0] lo_before, av, bv;
        reset = 1'b1; start = 0; op = 0; a = 0; b = 0;
        hilo_rd = 0; hi_we = 0; lo_we = 0; wdata = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);

        // mthi / mtlo in IDLE
        @(negedge clk); hi_we = 1; wdata = 32'h1234;
        @(negedge clk); hi_we = 0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo_kept", 64'(lo), 64'd0);
        lo_we = 1; wdata = 32'h0BAD_F00D;
        @(negedge clk); lo_we = 0;
        check("mtlo_lo", 64'(lo), 64'h0BAD_F00D);
        check("mtlo_hi_kept", 64'(hi), 64'h1234);
        hi_we = 1; lo_we = 1; wdata = 32'hCAFE_0001;
        @(negedge clk); hi_we = 0; lo_we = 0;
        check("mtboth_hi", 64'(hi), 64'hCAFE_0001);
        check("mtboth_lo", 64'(lo), 64'hCAFE_0001);

        // MULTU 7*6 with busy window length
        do_op(1'b0, 32'd7, 32'd6, 1'b1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("multu_busy_cycles", 64'(n), 64'(latency(1'b0, 32'd6) - 1));
        wait_drain();

        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op(1'b1, 32'd100, 32'd7, 1'b1);
        do_op(1'b1, 32'd5, 32'd0, 1'b1);
        do_op(1'b0, 32'd9, 32'd3, 1'b1);
        do_op(1'b0, 32'h1234_5678, 32'h8000_0000, 1'b1);
        do_op(1'b0, 32'hDEAD_BEEF, 32'd1, 1'b1);
        do_op(1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1);
        wait_drain();

        // hilo_rd held from cycle 3 stalls until busy drops
        do_op(1'b0, $urandom, $urandom, 1'b1);
        @(negedge clk);
        @(negedge clk);
        hilo_rd = 1'b1;
        #1;
        guard = 0;
        while (busy && guard < 100) begin
            check("hilo_rd_stall", 64'(stall), 64'd1);
            @(negedge clk);
            guard++;
        end
        check("hilo_rd_done_stall", 64'(stall), 64'd0);
        check("hilo_rd_done_pulse", 64'(done), 64'd1);
        hilo_rd = 1'b0;
        wait_drain();

        // start with mtlo in IDLE: start wins, write dropped
        @(negedge clk);
        lo_before = lo;
        start = 1; op = 0; a = 32'd3; b = 32'd5; lo_we = 1; wdata = 32'h0000_DEAD;
        #1;
        check("start_lowe_stall", 64'(stall), 64'd1);
        begin
            exp_t e;
            e = model(1'b0, 32'd3, 32'd5);
            e.cyc_done = cyc + latency(1'b0, 32'd5);
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 0; lo_we = 0;
        check("start_lowe_dropped", 64'(lo), 64'(lo_before));
        check("start_lowe_busy", 64'(busy), 64'd1);
        wait_drain();

        // reset in cycle 10 of a DIVU discards the op
        do_op(1'b1, 32'hFFFF_0000, 32'd13, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_hi", 64'(hi), 64'd0);
        check("midreset_lo", 64'(lo), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        repeat (40) @(negedge clk);
        check("midreset_idle", 64'(busy), 64'd0);

        // Randomized back-to-back ops with corner operands
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: bv = 32'd0;
                1: bv = 32'd1;
                2: bv = 32'h8000_0000;
                3: bv = $urandom_range(2, 255);
                default: bv = $urandom;
            endcase
            av = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
            do_op(1'($urandom_range(0, 1)), av, bv, 1'b1);
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
